// File: rtl/conv_result_writer_pkg.sv
// Shared definitions for the convolution result writer: FSM encoding,
// datapath widths and the frame-size helper.
package conv_result_writer_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } wr_state_t;

   // Element count of a frame, kept at 16 bits (8x8 product always fits).
   function automatic logic [15:0] frame_total(input logic [7:0] w, input logic [7:0] h);
      return 16'(w) * 16'(h);
   endfunction

endpackage

// File: rtl/result_fifo.sv
// Small skid FIFO between the convolution result stream and the SRAM
// write stage. Pointers carry one extra wrap bit to tell full from empty.
module result_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W:0]   r_wr_ptr;
   logic [PTR_W:0]   r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign o_data    = r_mem[r_rd_ptr[PTR_W-1:0]];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Storage array; contents are meaningless until a push, so no reset.
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
      end
   end

   // Read/write pointer advance; reset empties the FIFO.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/conv_result_writer.sv
// Writes a row-major convolution result stream into output SRAM as a
// 2-D frame (base address, width, height, row stride), one word per cycle.
module conv_result_writer
   import conv_result_writer_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        base_addr,
   input  logic [7:0]               out_w,
   input  logic [7:0]               out_h,
   input  logic [ADDR_W-1:0]        row_stride,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     in_ready,
   output logic                     sram_wen,
   output logic [ADDR_W-1:0]        sram_addr,
   output logic signed [DATA_W-1:0] sram_d,
   output logic                     busy,
   output logic                     done,
   output logic [15:0]              wr_count
);

   wr_state_t                r_state;
   logic [ADDR_W-1:0]        r_row_base;
   logic [ADDR_W-1:0]        r_stride;
   logic [7:0]               r_width;
   logic [7:0]               r_col;
   logic [15:0]              r_total;
   logic [15:0]              r_accepted;
   logic [15:0]              r_wr_count;
   logic                     r_sram_wen;
   logic [ADDR_W-1:0]        r_sram_addr;
   logic signed [DATA_W-1:0] r_sram_d;
   logic                     r_busy;
   logic                     r_done;

   logic                     w_start_acc;
   logic [15:0]              w_start_total;
   logic                     w_in_ready;
   logic                     w_push;
   logic                     w_pop;
   logic                     w_full;
   logic                     w_empty;
   logic [DATA_W-1:0]        w_fifo_q;
   logic [ADDR_W-1:0]        w_col_ext;

   assign w_start_acc   = start && (r_state == ST_IDLE);
   assign w_start_total = frame_total(out_w, out_h);
   assign w_in_ready    = (r_state == ST_RUN) && !w_full && (r_accepted < r_total);
   assign w_push        = in_valid && w_in_ready;
   assign w_pop         = (r_state == ST_RUN) && !w_empty;
   assign w_col_ext     = {{(ADDR_W-8){1'b0}}, r_col};

   result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (in_data),
      .o_data  (w_fifo_q),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Frame control FSM with registered busy/done; FIN is entered once the
   // frame's final write is on the SRAM port, so done follows that write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_busy <= 1'b1;
                  if (w_start_total == '0) begin
                     r_state <= ST_FIN;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (r_sram_wen && (r_wr_count == r_total)) begin
                  r_state <= ST_FIN;
                  r_done  <= 1'b1;
               end
            end
            ST_FIN: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // Frame configuration latch and input acceptance count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stride   <= '0;
         r_width    <= '0;
         r_total    <= '0;
         r_accepted <= '0;
      end else if (w_start_acc) begin
         r_stride   <= row_stride;
         r_width    <= out_w;
         r_total    <= w_start_total;
         r_accepted <= '0;
      end else if (w_push) begin
         r_accepted <= r_accepted + 16'd1;
      end
   end

   // Address generation: walk columns, step row base by stride at row end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row_base <= '0;
         r_col      <= '0;
      end else if (w_start_acc) begin
         r_row_base <= base_addr;
         r_col      <= '0;
      end else if (w_pop) begin
         if (r_col == r_width - 8'd1) begin
            r_col      <= '0;
            r_row_base <= r_row_base + r_stride;
         end else begin
            r_col <= r_col + 8'd1;
         end
      end
   end

   // SRAM write port: one registered write per FIFO pop; addr/data hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sram_wen  <= 1'b0;
         r_sram_addr <= '0;
         r_sram_d    <= '0;
         r_wr_count  <= '0;
      end else begin
         r_sram_wen <= w_pop;
         if (w_pop) begin
            r_sram_addr <= r_row_base + w_col_ext;
            r_sram_d    <= w_fifo_q;
         end
         if (w_start_acc) begin
            r_wr_count <= '0;
         end else if (w_pop) begin
            r_wr_count <= r_wr_count + 16'd1;
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign sram_wen  = r_sram_wen;
   assign sram_addr = r_sram_addr;
   assign sram_d    = r_sram_d;
   assign busy      = r_busy;
   assign done      = r_done;
   assign wr_count  = r_wr_count;

endmodule

// File: tb/tb_conv_result_writer.sv
// Directed testbench for conv_result_writer: frame writes, input gaps,
// zero-size frame, address wrap, surplus input, reset mid-frame.
module tb_conv_result_writer;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic [15:0]        base_addr;
   logic [7:0]         out_w;
   logic [7:0]         out_h;
   logic [15:0]        row_stride;
   logic               in_valid;
   logic signed [31:0] in_data;
   logic               in_ready;
   logic               sram_wen;
   logic [15:0]        sram_addr;
   logic signed [31:0] sram_d;
   logic               busy;
   logic               done;
   logic [15:0]        wr_count;

   int n_vec  = 0;
   int n_miss = 0;

   int cyc_cnt   = 0;
   int done_cnt  = 0;
   int done_cyc  = -1;
   int busy_cnt  = 0;
   logic [15:0] wa_q[$];
   logic [31:0] wd_q[$];
   int          wc_q[$];
   int          acc_q[$];

   conv_result_writer #(
      .FIFO_DEPTH (4),
      .ADDR_W     (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .out_w      (out_w),
      .out_h      (out_h),
      .row_stride (row_stride),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .sram_wen   (sram_wen),
      .sram_addr  (sram_addr),
      .sram_d     (sram_d),
      .busy       (busy),
      .done       (done),
      .wr_count   (wr_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt++;

   // Observe the SRAM port and status away from the active edge.
   always @(negedge clk) begin
      if (sram_wen) begin
         wa_q.push_back(sram_addr);
         wd_q.push_back(sram_d);
         wc_q.push_back(cyc_cnt);
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc_cnt;
      end
      if (busy) busy_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      wa_q.delete();
      wd_q.delete();
      wc_q.delete();
      acc_q.delete();
      done_cnt = 0;
      done_cyc = -1;
      busy_cnt = 0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_wen"},   32'(sram_wen),  32'd0);
      chk({tag, "_addr"},  32'(sram_addr), 32'd0);
      chk({tag, "_d"},     32'(sram_d),    32'd0);
      chk({tag, "_rdy"},   32'(in_ready),  32'd0);
      chk({tag, "_busy"},  32'(busy),      32'd0);
      chk({tag, "_done"},  32'(done),      32'd0);
      chk({tag, "_wrcnt"}, 32'(wr_count),  32'd0);
   endtask

   // Called just after a rising edge; leaves start high for one cycle.
   task automatic do_start(input logic [15:0] b, input logic [7:0] w, input logic [7:0] h,
                           input logic [15:0] s, output int scyc);
      base_addr  = b;
      out_w      = w;
      out_h      = h;
      row_stride = s;
      start      = 1'b1;
      scyc       = cyc_cnt;
      @(posedge clk); #1;
      start      = 1'b0;
      base_addr  = 16'hDEAD;
      out_w      = 8'hEE;
      out_h      = 8'hEE;
      row_stride = 16'hBEEF;
   endtask

   // Offer items dbase+1.. one at a time; an item advances only on handshake.
   task automatic feed(input int n, input bit toggle, input int dbase, input int budget,
                       output int got);
      int idx = 0;
      for (int c = 0; c < budget && idx < n; c++) begin
         in_valid = toggle ? (c % 2 == 0) : 1'b1;
         in_data  = 32'(dbase + idx + 1);
         @(negedge clk);
         if (in_valid && in_ready) begin
            acc_q.push_back(cyc_cnt);
            idx++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_data  = 32'h0;
      got      = idx;
   endtask

   task automatic wait_done(input string tag, input int budget);
      for (int c = 0; c < budget; c++) begin
         @(negedge clk); #1;
         if (done_cnt > 0) break;
      end
      chk({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
      repeat (2) begin
         @(posedge clk); #1;
      end
   endtask

   // Expected writes from the frame geometry: addr = base + row*stride + col (mod 2^16).
   task automatic chk_frame(input string tag, input logic [15:0] b, input logic [15:0] s,
                            input int w, input int h, input int dbase, input bit lat);
      int n;
      logic [15:0] ea;
      n = w * h;
      chk({tag, "_nwr"}, 32'(wa_q.size()), 32'(n));
      for (int i = 0; i < n && i < wa_q.size(); i++) begin
         ea = 16'(int'(b) + (i / w) * int'(s) + (i % w));
         chk($sformatf("%s_addr%0d", tag, i), 32'(wa_q[i]), 32'(ea));
         chk($sformatf("%s_data%0d", tag, i), wd_q[i], 32'(dbase + i + 1));
         if (lat && i < acc_q.size())
            chk($sformatf("%s_lat%0d", tag, i), 32'(wc_q[i]), 32'(acc_q[i] + 2));
      end
   endtask

   initial begin
      int scyc;
      int got;
      rst_n      = 1'b0;
      start      = 1'b0;
      base_addr  = '0;
      out_w      = '0;
      out_h      = '0;
      row_stride = '0;
      in_valid   = 1'b0;
      in_data    = '0;
      #2;
      chk_reset_outputs("por");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic 3x2 frame, continuous input.
      clear_mon();
      do_start(16'h0100, 8'd3, 8'd2, 16'h0010, scyc);
      feed(6, 1'b0, 0, 40, got);
      wait_done("f1", 40);
      chk("f1_acc", 32'(got), 32'd6);
      chk_frame("f1", 16'h0100, 16'h0010, 3, 2, 0, 1'b1);
      chk("f1_addr_last", 32'(wa_q.size() == 6 ? wa_q[5] : 16'h0), 32'h0112);
      chk("f1_done_cnt", 32'(done_cnt), 32'd1);
      chk("f1_done_cyc", 32'(done_cyc), 32'(wc_q.size() > 0 ? wc_q[wc_q.size()-1] + 1 : -1));
      chk("f1_wrcnt", 32'(wr_count), 32'd6);
      chk("f1_busy_end", 32'(busy), 32'd0);

      // Same frame, input valid every other cycle.
      clear_mon();
      do_start(16'h0100, 8'd3, 8'd2, 16'h0010, scyc);
      feed(6, 1'b1, 0, 60, got);
      wait_done("f2", 40);
      chk("f2_acc", 32'(got), 32'd6);
      chk_frame("f2", 16'h0100, 16'h0010, 3, 2, 0, 1'b1);
      chk("f2_done_cnt", 32'(done_cnt), 32'd1);
      chk("f2_wrcnt", 32'(wr_count), 32'd6);

      // Zero-size frame.
      clear_mon();
      do_start(16'h0500, 8'd0, 8'd5, 16'h0010, scyc);
      repeat (4) begin
         @(posedge clk); #1;
      end
      chk("z_nwr", 32'(wa_q.size()), 32'd0);
      chk("z_done_cnt", 32'(done_cnt), 32'd1);
      chk("z_done_cyc", 32'(done_cyc), 32'(scyc + 1));
      chk("z_busy_cycles", 32'(busy_cnt), 32'd1);
      chk("z_wrcnt", 32'(wr_count), 32'd0);

      // Address wrap at top of address space.
      clear_mon();
      do_start(16'hFFFE, 8'd4, 8'd1, 16'h0040, scyc);
      feed(4, 1'b0, 100, 40, got);
      wait_done("wrap", 40);
      chk_frame("wrap", 16'hFFFE, 16'h0040, 4, 1, 100, 1'b1);
      chk("wrap_a2", 32'(wa_q.size() > 2 ? wa_q[2] : 16'hFFFF), 32'h0000);
      chk("wrap_a3", 32'(wa_q.size() > 3 ? wa_q[3] : 16'hFFFF), 32'h0001);

      // Surplus input and a start pulse while running.
      clear_mon();
      do_start(16'h0200, 8'd2, 8'd4, 16'h0020, scyc);
      do_start(16'h7000, 8'd5, 8'd5, 16'h0100, scyc);
      feed(10, 1'b0, 200, 25, got);
      wait_done("sur", 20);
      chk("sur_acc", 32'(got), 32'd8);
      chk("sur_accq", 32'(acc_q.size()), 32'd8);
      chk_frame("sur", 16'h0200, 16'h0020, 2, 4, 200, 1'b0);
      chk("sur_done_cnt", 32'(done_cnt), 32'd1);
      chk("sur_wrcnt", 32'(wr_count), 32'd8);

      // Reset after three writes, then a clean frame.
      clear_mon();
      do_start(16'h0300, 8'd3, 8'd2, 16'h0010, scyc);
      fork
         feed(6, 1'b0, 0, 30, got);
         begin
            for (int c = 0; c < 40; c++) begin
               @(negedge clk); #2;
               if (wa_q.size() >= 3) break;
            end
            rst_n = 1'b0;
            #1;
            chk_reset_outputs("mid");
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
         end
      join
      chk("mid_nwr", 32'(wa_q.size()), 32'd3);
      for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
         chk($sformatf("mid_addr%0d", i), 32'(wa_q[i]), 32'(16'h0300 + 16'(i)));
         chk($sformatf("mid_data%0d", i), wd_q[i], 32'(i + 1));
      end
      chk("mid_done_cnt", 32'(done_cnt), 32'd0);

      clear_mon();
      do_start(16'h0400, 8'd3, 8'd2, 16'h0010, scyc);
      feed(6, 1'b0, 10, 40, got);
      wait_done("post", 40);
      chk_frame("post", 16'h0400, 16'h0010, 3, 2, 10, 1'b1);
      chk("post_done_cnt", 32'(done_cnt), 32'd1);
      chk("post_wrcnt", 32'(wr_count), 32'd6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
